// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store, with per-side result buffers and an access watchdog.
// Define RISCV_ARB_FAIR_EN for round-robin grant when both sides are pending.
module riscv_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              inst_adv_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_stall_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic              data_adv_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              ibuf_valid;
  logic [ADDR_W-1:0] ibuf_addr;
  logic              dbuf_valid;
  logic [ADDR_W-1:0] dbuf_addr;
  logic              dbuf_we;
  logic              inst_hit;
  logic              data_hit;
  logic              grant_data;
  logic              done;
  logic [DATA_W-1:0] fill_data;

  assign inst_hit     = ibuf_valid && (ibuf_addr == inst_addr_i);
  assign data_hit     = dbuf_valid && (dbuf_addr == data_addr_i) && (dbuf_we == data_we_i);
  assign inst_stall_o = inst_ce_i && !inst_hit;
  assign data_stall_o = data_ce_i && !data_hit;

  // Timeout is the edge where the counter would reach MAX_WAIT; an ack on that cycle still wins.
  assign done      = mem_ack_i || (cnt == CNT_LAST);
  assign fill_data = (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;

`ifdef RISCV_ARB_FAIR_EN
  logic last_data;
  assign grant_data = data_stall_o && (!inst_stall_o || !last_data);
`else
  assign grant_data = data_stall_o;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      err_o        <= 1'b0;
      ibuf_valid   <= 1'b0;
      ibuf_addr    <= '0;
      inst_o       <= '0;
      dbuf_valid   <= 1'b0;
      dbuf_addr    <= '0;
      dbuf_we      <= 1'b0;
      data_rdata_o <= '0;
`ifdef RISCV_ARB_FAIR_EN
      last_data    <= 1'b0;
`endif
    end else begin
      if (inst_adv_i && inst_hit) ibuf_valid <= 1'b0;
      if (data_adv_i && data_hit) dbuf_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            mem_addr_o  <= data_addr_i;
            mem_we_o    <= data_we_i;
            mem_wdata_o <= data_wdata_i;
            mem_req_o   <= 1'b1;
            state       <= BUSY_D;
`ifdef RISCV_ARB_FAIR_EN
            last_data   <= 1'b1;
`endif
          end else if (inst_stall_o) begin
            mem_addr_o  <= inst_addr_i;
            mem_we_o    <= 1'b0;
            mem_req_o   <= 1'b1;
            state       <= BUSY_I;
`ifdef RISCV_ARB_FAIR_EN
            last_data   <= 1'b0;
`endif
          end
        end
        default: begin
          if (done) begin
            if (!mem_ack_i) err_o <= 1'b1;
            if (state == BUSY_I) begin
              ibuf_valid <= 1'b1;
              ibuf_addr  <= mem_addr_o;
              inst_o     <= fill_data;
            end else begin
              dbuf_valid   <= 1'b1;
              dbuf_addr    <= mem_addr_o;
              dbuf_we      <= mem_we_o;
              data_rdata_o <= fill_data;
            end
            mem_req_o <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: fetch, priority, store, redirect, timeout and async reset.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ce_i, inst_adv_i, inst_stall_o;
  logic [31:0] inst_addr_i, inst_o;
  logic        data_ce_i, data_we_i, data_adv_i, data_stall_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_adv_i(inst_adv_i),
    .inst_o(inst_o), .inst_stall_o(inst_stall_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_adv_i(data_adv_i),
    .data_rdata_o(data_rdata_o), .data_stall_o(data_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inst_ce_i = 0; inst_addr_i = '0; inst_adv_i = 0;
    data_ce_i = 0; data_we_i = 0; data_addr_i = '0; data_wdata_i = '0; data_adv_i = 0;
    mem_ack_i = 0; mem_rdata_i = '0;
    #2;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_rdata", data_rdata_o, 32'h0);
    #10 rst_n = 1'b1;

    // fetch 0x100
    inst_ce_i = 1; inst_addr_i = 32'h100;
    #1 chk("f_stall0", {31'd0, inst_stall_o}, 32'd1);
    cyc();
    chk("f_req", {31'd0, mem_req_o}, 32'd1);
    chk("f_addr", mem_addr_o, 32'h100);
    chk("f_we", {31'd0, mem_we_o}, 32'd0);
    mem_ack_i = 1; mem_rdata_i = 32'h00A00093;
    #1 chk("f_stall1", {31'd0, inst_stall_o}, 32'd1);
    cyc();
    mem_ack_i = 0; inst_adv_i = 1;
    #1;
    chk("f_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("f_inst", inst_o, 32'h00A00093);
    chk("f_stall_lo", {31'd0, inst_stall_o}, 32'd0);
    cyc();
    inst_adv_i = 0;
    #1 chk("f_consumed", {31'd0, inst_stall_o}, 32'd1);

    // simultaneous load 0x200 and fetch 0x104
    inst_addr_i = 32'h104;
    data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h200;
    #1 chk("s_istall", {31'd0, inst_stall_o}, 32'd1);
    cyc();
    chk("s_d_addr", mem_addr_o, 32'h200);
    chk("s_d_we", {31'd0, mem_we_o}, 32'd0);
    mem_ack_i = 1; mem_rdata_i = 32'h11112222;
    cyc();
    mem_ack_i = 0; data_adv_i = 1;
    #1;
    chk("s_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("s_rdata", data_rdata_o, 32'h11112222);
    chk("s_dstall", {31'd0, data_stall_o}, 32'd0);
    chk("s_istall2", {31'd0, inst_stall_o}, 32'd1);
    cyc();
    data_adv_i = 0; data_ce_i = 0;
    chk("s_i_addr", mem_addr_o, 32'h104);
    chk("s_i_req", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1; mem_rdata_i = 32'h00B00113;
    cyc();
    mem_ack_i = 0;
    #1;
    chk("s_inst", inst_o, 32'h00B00113);
    chk("s_istall_lo", {31'd0, inst_stall_o}, 32'd0);
    chk("s_rdata_keep", data_rdata_o, 32'h11112222);

    // store 0x300 <= DEADBEEF, then identical store re-issues
    inst_ce_i = 0;
    data_ce_i = 1; data_we_i = 1; data_addr_i = 32'h300; data_wdata_i = 32'hDEADBEEF;
    #1 chk("st_stall", {31'd0, data_stall_o}, 32'd1);
    cyc();
    chk("st_we", {31'd0, mem_we_o}, 32'd1);
    chk("st_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("st_addr", mem_addr_o, 32'h300);
    cyc();
    chk("st_hold_we", {31'd0, mem_we_o}, 32'd1);
    chk("st_hold_wd", mem_wdata_o, 32'hDEADBEEF);
    chk("st_hold_req", {31'd0, mem_req_o}, 32'd1);
    chk("st_hold_stall", {31'd0, data_stall_o}, 32'd1);
    mem_ack_i = 1; mem_rdata_i = 32'h55555555;
    cyc();
    mem_ack_i = 0; data_adv_i = 1;
    #1;
    chk("st_stall_lo", {31'd0, data_stall_o}, 32'd0);
    chk("st_rdata0", data_rdata_o, 32'h0);
    cyc();
    data_adv_i = 0;
    #1 chk("st_reissue", {31'd0, data_stall_o}, 32'd1);
    cyc();
    chk("st2_req", {31'd0, mem_req_o}, 32'd1);
    chk("st2_we", {31'd0, mem_we_o}, 32'd1);
    mem_ack_i = 1; mem_rdata_i = 32'h0;
    cyc();
    mem_ack_i = 0; data_ce_i = 0;

    // redirect 0x108 -> 0x400 while BUSY_I
    inst_ce_i = 1; inst_addr_i = 32'h108;
    cyc();
    chk("r_addr108", mem_addr_o, 32'h108);
    inst_addr_i = 32'h400;
    #1 chk("r_stall", {31'd0, inst_stall_o}, 32'd1);
    cyc();
    chk("r_hold", mem_addr_o, 32'h108);
    mem_ack_i = 1; mem_rdata_i = 32'hAAAA0001;
    cyc();
    mem_ack_i = 0;
    #1;
    chk("r_stall_old", {31'd0, inst_stall_o}, 32'd1);
    chk("r_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("r_inst_old", inst_o, 32'hAAAA0001);
    cyc();
    chk("r_addr400", mem_addr_o, 32'h400);
    chk("r_req400", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1; mem_rdata_i = 32'hBBBB0002;
    cyc();
    mem_ack_i = 0;
    #1;
    chk("r_stall_lo", {31'd0, inst_stall_o}, 32'd0);
    chk("r_inst_new", inst_o, 32'hBBBB0002);
    inst_ce_i = 0;

    // timeout: load 0x500, no ack for 15 BUSY cycles
    data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h500;
    cyc();
    chk("t_req", {31'd0, mem_req_o}, 32'd1);
    repeat (14) cyc();
    chk("t_c15_req", {31'd0, mem_req_o}, 32'd1);
    chk("t_c15_err", {31'd0, err_o}, 32'd0);
    chk("t_c15_stall", {31'd0, data_stall_o}, 32'd1);
    cyc();
    data_adv_i = 1;
    #1;
    chk("t_err", {31'd0, err_o}, 32'd1);
    chk("t_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("t_rdata0", data_rdata_o, 32'h0);
    chk("t_stall_lo", {31'd0, data_stall_o}, 32'd0);
    cyc();
    data_adv_i = 0;
    #1 chk("t2_stall", {31'd0, data_stall_o}, 32'd1);
    cyc();
    repeat (14) cyc();
    chk("t2_c15_req", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1; mem_rdata_i = 32'h12345678;
    cyc();
    mem_ack_i = 0; data_adv_i = 1;
    #1;
    chk("t2_rdata", data_rdata_o, 32'h12345678);
    chk("t2_stall_lo", {31'd0, data_stall_o}, 32'd0);
    chk("t2_err_sticky", {31'd0, err_o}, 32'd1);
    cyc();
    data_adv_i = 0;

    // async reset mid BUSY_D, then stale ack in IDLE
    cyc();
    chk("a_req", {31'd0, mem_req_o}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("a_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("a_err", {31'd0, err_o}, 32'd0);
    chk("a_rdata", data_rdata_o, 32'h0);
    #2 rst_n = 1'b1;
    #1 chk("a_stall", {31'd0, data_stall_o}, 32'd1);
    data_ce_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hFFFF0000;
    cyc();
    mem_ack_i = 0;
    chk("a_stale_req", {31'd0, mem_req_o}, 32'd0);
    chk("a_stale_rd", data_rdata_o, 32'h0);
    chk("a_stale_err", {31'd0, err_o}, 32'd0);
    data_ce_i = 1;
    #1 chk("a_stale_stall", {31'd0, data_stall_o}, 32'd1);
    cyc();
    chk("a_reissue_req", {31'd0, mem_req_o}, 32'd1);
    chk("a_reissue_addr", mem_addr_o, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
